// File: rtl/aq_axils_pkg.sv
// rtl/aq_axils_pkg.sv - shared AXI4-Lite bridge types and response codes
package aq_axils_pkg;

  // Bridge sequencing: accept in IDLE, hold the local strobe in *_ACC, present the response in *_RESP
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ACC  = 3'd1,
    RD_ACC  = 3'd2,
    WR_RESP = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/aq_axils_local_bridge_if.sv
// rtl/aq_axils_local_bridge_if.sv - AXI4-Lite host side and local-bus side of the bridge
interface aq_axils_local_bridge_if;

  // AXI4-Lite write address / data / response
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  // AXI4-Lite read address / data
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  // Single-beat local bus toward the register blocks
  logic        local_cs;
  logic        local_rnw;
  logic        local_ack;
  logic [31:0] local_addr;
  logic [3:0]  local_be;
  logic [31:0] local_wdata;
  logic [31:0] local_rdata;

  // Bridge view: AXI slave, local-bus initiator
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arvalid, rready,
    input  local_ack, local_rdata,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid,
    output local_cs, local_rnw, local_addr, local_be, local_wdata
  );

  // Host / register-block view
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arvalid, rready,
    output local_ack, local_rdata,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid,
    input  local_cs, local_rnw, local_addr, local_be, local_wdata
  );

endinterface

// File: rtl/aq_axils_local_bridge.sv
// rtl/aq_axils_local_bridge.sv - AXI4-Lite slave to single-beat local bus bridge with access timeout
module aq_axils_local_bridge
  import aq_axils_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  aq_axils_local_bridge_if.slave bus
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          last_write;
  logic          wr_req;
  logic          rd_req;
  logic          wr_grant;
  logic          rd_grant;
  logic          in_acc;
  logic          expired;
  logic          acc_done;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [3:0]    be_q;
  logic          rnw_q;
  logic [1:0]    bresp_q;
  logic [1:0]    rresp_q;

  assign wr_req   = bus.awvalid & bus.wvalid;
  assign rd_req   = bus.arvalid;
  assign in_acc   = (state == WR_ACC) || (state == RD_ACC);
  assign expired  = (cnt == CNT_LAST);
  assign acc_done = in_acc && (bus.local_ack || expired);

  // Next state and accept decision; on contention the type not served last wins
  always_comb begin
    state_next = state;
    wr_grant   = 1'b0;
    rd_grant   = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (wr_req && (!rd_req || !last_write)) begin
            wr_grant   = 1'b1;
            state_next = WR_ACC;
          end else if (rd_req) begin
            rd_grant   = 1'b1;
            state_next = RD_ACC;
          end
        end
      end
      WR_ACC:  if (bus.local_ack || expired) state_next = WR_RESP;
      RD_ACC:  if (bus.local_ack || expired) state_next = RD_RESP;
      WR_RESP: if (bus.bready) state_next = IDLE;
      RD_RESP: if (bus.rready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Timeout counter: cleared on accept, advances each access cycle that does not finish
  always_ff @(posedge clk) begin
    if (rst || wr_grant || rd_grant) cnt <= '0;
    else if (in_acc && !acc_done)    cnt <= cnt + CW'(1);
  end

  // Access latches, arbitration history and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rnw_q      <= 1'b1;
      last_write <= 1'b0;
      rdata_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
    end else begin
      if (wr_grant) begin
        addr_q     <= bus.awaddr;
        wdata_q    <= bus.wdata;
        be_q       <= bus.wstrb;
        rnw_q      <= 1'b0;
        last_write <= 1'b1;
      end else if (rd_grant) begin
        addr_q     <= bus.araddr;
        be_q       <= 4'hF;
        rnw_q      <= 1'b1;
        last_write <= 1'b0;
      end
      // A late ack coinciding with expiry still counts as success
      if (acc_done && state == WR_ACC) begin
        bresp_q <= bus.local_ack ? RESP_OKAY : RESP_SLVERR;
      end
      if (acc_done && state == RD_ACC) begin
        rresp_q <= bus.local_ack ? RESP_OKAY : RESP_SLVERR;
        rdata_q <= bus.local_ack ? bus.local_rdata : 32'h0;
      end
      // Read data is only visible while the read response is pending
      if (state == RD_RESP && bus.rready) rdata_q <= '0;
    end
  end

  assign bus.awready     = wr_grant;
  assign bus.wready      = wr_grant;
  assign bus.arready     = rd_grant;
  assign bus.bvalid      = (state == WR_RESP);
  assign bus.rvalid      = (state == RD_RESP);
  assign bus.bresp       = bresp_q;
  assign bus.rresp       = rresp_q;
  assign bus.rdata       = rdata_q;
  assign bus.local_cs    = in_acc;
  assign bus.local_rnw   = rnw_q;
  assign bus.local_addr  = addr_q;
  assign bus.local_be    = be_q;
  assign bus.local_wdata = wdata_q;

endmodule

// File: tb/tb_aq_axils_local_bridge.sv
// tb/tb_aq_axils_local_bridge.sv - self-checking bench for the AXI4-Lite local bus bridge
module tb_aq_axils_local_bridge;

  localparam int TO     = 8;
  localparam int BUDGET = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aq_axils_local_bridge_if bus ();

  aq_axils_local_bridge #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Local register-block model: 0 = combinational ack, 1 = registered ack,
  // 2 = never acks, 3 = acks exactly in the last cycle before timeout
  int   ack_mode  = 0;
  logic stray_ack = 1'b0;
  logic ack_reg   = 1'b0;
  int   cs_run    = 0;
  logic [31:0] slv_mem [16] = '{default: 32'h0};
  logic [31:0] exp_mem [16] = '{default: 32'h0};

  assign bus.local_ack = stray_ack |
                         ((ack_mode == 0) ? bus.local_cs :
                          (ack_mode == 1) ? ack_reg :
                          (ack_mode == 3) ? (bus.local_cs && cs_run == TO - 1) : 1'b0);
  assign bus.local_rdata = slv_mem[bus.local_addr[5:2]];

  always @(posedge clk) begin
    ack_reg <= (ack_mode == 1) && bus.local_cs && !ack_reg;
    cs_run  <= bus.local_cs ? cs_run + 1 : 0;
    if (bus.local_cs && bus.local_ack && !bus.local_rnw) begin
      for (int b = 0; b < 4; b++)
        if (bus.local_be[b]) slv_mem[bus.local_addr[5:2]][8*b +: 8] <= bus.local_wdata[8*b +: 8];
    end
  end

  // Strobe monitor: high cycles, rising edges, low gap before the latest rise, stability
  int   cs_cycles = 0;
  int   cs_rises  = 0;
  int   low_run   = 0;
  int   last_gap  = 0;
  int   stab_err  = 0;
  logic cs_prev   = 1'b0;
  logic [31:0] mon_addr  = '0;
  logic [31:0] mon_wdata = '0;
  logic [3:0]  mon_be    = '0;
  logic        mon_rnw   = 1'b0;

  always @(posedge clk) begin
    if (bus.local_cs === 1'b1) begin
      cs_cycles++;
      if (!cs_prev) begin
        last_gap = low_run;
        cs_rises++;
      end else if (bus.local_addr !== mon_addr || bus.local_be !== mon_be ||
                   bus.local_wdata !== mon_wdata || bus.local_rnw !== mon_rnw) begin
        stab_err++;
      end
      mon_addr  = bus.local_addr;
      mon_be    = bus.local_be;
      mon_wdata = bus.local_wdata;
      mon_rnw   = bus.local_rnw;
      low_run   = 0;
    end else begin
      low_run++;
    end
    cs_prev = (bus.local_cs === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int bdelay,
                           output logic [1:0] resp, output int lat, output bit ok);
    int g;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = (bdelay == 0);
    #1;
    g = 0;
    while (!(bus.awready && bus.wready) && g < BUDGET) begin tick(); g++; end
    ok = bus.awready && bus.wready;
    resp = 2'b11; lat = 0;
    if (!ok) begin bus.awvalid = 1'b0; bus.wvalid = 1'b0; return; end
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    lat = 1;
    #1;
    while (!bus.bvalid && lat < BUDGET) begin tick(); lat++; end
    ok = bus.bvalid;
    resp = bus.bresp;
    repeat (bdelay) tick();
    bus.bready = 1'b1;
    #1;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, input int rdelay,
                          output logic [31:0] data, output logic [1:0] resp, output int lat, output bit ok);
    int g;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = (rdelay == 0);
    #1;
    g = 0;
    while (!bus.arready && g < BUDGET) begin tick(); g++; end
    ok = bus.arready;
    data = '0; resp = 2'b11; lat = 0;
    if (!ok) begin bus.arvalid = 1'b0; return; end
    tick();
    bus.arvalid = 1'b0;
    lat = 1;
    #1;
    while (!bus.rvalid && lat < BUDGET) begin tick(); lat++; end
    ok = bus.rvalid;
    data = bus.rdata;
    resp = bus.rresp;
    repeat (rdelay) tick();
    bus.rready = 1'b1;
    #1;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.local_cs} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b want 000000",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.local_cs});
    end
    n_tests++;
    if ({bus.local_addr, bus.local_wdata, bus.rdata, bus.bresp, bus.rresp} !== 100'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h rdata %h bresp %b rresp %b want all zero",
               bus.local_addr, bus.local_wdata, bus.rdata, bus.bresp, bus.rresp);
    end
    n_tests++;
    if (bus.local_rnw !== 1'b1 || bus.local_be !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_rnw_be: rnw %b be %h want 1 / 0", bus.local_rnw, bus.local_be);
    end
    // Requests presented while reset is held must not be accepted
    rst = 1'b1;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    tick();
    n_tests++;
    if ({bus.awready, bus.wready, bus.arready, bus.local_cs} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_no_accept: got %b want 0000", {bus.awready, bus.wready, bus.arready, bus.local_cs});
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_write_readback();
    logic [1:0]  resp;
    logic [31:0] data;
    int lat, c0;
    bit ok;
    ack_mode = 0;
    c0 = cs_cycles;
    axi_write(32'h10, 32'h12345678, 4'hF, 0, resp, lat, ok);
    exp_mem[4] = merge(exp_mem[4], 32'h12345678, 4'hF);
    n_tests++;
    if (!ok || lat !== 2 || resp !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_basic: ok %0d lat %0d bresp %b want 1 2 00", ok, lat, resp);
    end
    n_tests++;
    if (cs_cycles - c0 !== 1 || mon_addr !== 32'h10 || mon_be !== 4'hF || mon_rnw !== 1'b0 || mon_wdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL wr_local: cs %0d addr %h be %h rnw %b wdata %h want 1 10 f 0 12345678",
               cs_cycles - c0, mon_addr, mon_be, mon_rnw, mon_wdata);
    end
    ack_mode = 1;
    c0 = cs_cycles;
    axi_read(32'h10, 0, data, resp, lat, ok);
    n_tests++;
    if (!ok || lat !== 3 || resp !== 2'b00 || data !== exp_mem[4]) begin
      n_fail++;
      $display("FAIL rd_basic: ok %0d lat %0d rresp %b data %h want 1 3 00 %h", ok, lat, resp, data, exp_mem[4]);
    end
    n_tests++;
    if (cs_cycles - c0 !== 2 || mon_be !== 4'hF || mon_rnw !== 1'b1 || bus.rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_local: cs %0d be %h rnw %b idle_rdata %h want 2 f 1 0", cs_cycles - c0, mon_be, mon_rnw, bus.rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  r1, r2;
    logic [31:0] d1, d2, data;
    logic [3:0]  s2;
    int l1, l2, r0;
    bit o1, o2;
    ack_mode = 0;
    d1 = $urandom; d2 = $urandom; s2 = 4'($urandom_range(1, 15));
    r0 = cs_rises;
    axi_write(32'h00, d1, 4'hF, 0, r1, l1, o1);
    axi_write(32'h00, d2, s2, 0, r2, l2, o2);
    exp_mem[0] = merge(merge(exp_mem[0], d1, 4'hF), d2, s2);
    n_tests++;
    if (!o1 || !o2 || r1 !== 2'b00 || r2 !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_resp: ok %0d %0d resp %b %b want 1 1 00 00", o1, o2, r1, r2);
    end
    n_tests++;
    if (cs_rises - r0 !== 2 || last_gap < 2) begin
      n_fail++;
      $display("FAIL b2b_pulses: rises %0d gap %0d want 2 and >=2", cs_rises - r0, last_gap);
    end
    axi_read(32'h00, 0, data, r1, l1, o1);
    n_tests++;
    if (!o1 || data !== exp_mem[0]) begin
      n_fail++;
      $display("FAIL b2b_readback: data %h want %h", data, exp_mem[0]);
    end
  endtask

  task automatic test_arbitration();
    logic [31:0] da, db, data;
    logic [1:0]  resp;
    int g, lat;
    bit ok;
    do_reset();
    ack_mode = 0;
    da = $urandom; db = $urandom;
    bus.bready = 1'b1; bus.rready = 1'b1;
    bus.awaddr = 32'h20; bus.wdata = da; bus.wstrb = 4'hF; bus.araddr = 32'h24;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    #1;
    n_tests++;
    if (!(bus.awready === 1'b1 && bus.wready === 1'b1 && bus.arready === 1'b0)) begin
      n_fail++;
      $display("FAIL arb_first: aw %b w %b ar %b want 1 1 0", bus.awready, bus.wready, bus.arready);
    end
    tick();
    bus.awaddr = 32'h28; bus.wdata = db;
    g = 0;
    while (!(bus.awready || bus.arready) && g < BUDGET) begin tick(); g++; end
    n_tests++;
    if (!(bus.arready === 1'b1 && bus.awready === 1'b0)) begin
      n_fail++;
      $display("FAIL arb_second: aw %b ar %b want 0 1", bus.awready, bus.arready);
    end
    tick();
    bus.arvalid = 1'b0;
    g = 0;
    while (!bus.awready && g < BUDGET) begin tick(); g++; end
    n_tests++;
    if (bus.awready !== 1'b1) begin
      n_fail++;
      $display("FAIL arb_third: aw %b want 1", bus.awready);
    end
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    repeat (4) tick();
    bus.bready = 1'b0; bus.rready = 1'b0;
    exp_mem[8]  = da;
    exp_mem[10] = db;
    axi_read(32'h20, 0, data, resp, lat, ok);
    n_tests++;
    if (!ok || data !== exp_mem[8]) begin
      n_fail++;
      $display("FAIL arb_data_a: data %h want %h", data, exp_mem[8]);
    end
    axi_read(32'h28, 0, data, resp, lat, ok);
    n_tests++;
    if (!ok || data !== exp_mem[10]) begin
      n_fail++;
      $display("FAIL arb_data_b: data %h want %h", data, exp_mem[10]);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] data;
    logic [1:0]  resp;
    int lat, c0;
    bit ok;
    ack_mode = 2;
    c0 = cs_cycles;
    axi_read(32'h30, 0, data, resp, lat, ok);
    n_tests++;
    if (!ok || cs_cycles - c0 !== TO || lat !== TO + 1 || resp !== 2'b10 || data !== 32'h0) begin
      n_fail++;
      $display("FAIL to_read: cs %0d lat %0d rresp %b data %h want %0d %0d 10 0", cs_cycles - c0, lat, resp, data, TO, TO + 1);
    end
    c0 = cs_cycles;
    axi_write(32'h34, $urandom, 4'hF, 1, resp, lat, ok);
    n_tests++;
    if (!ok || cs_cycles - c0 !== TO || resp !== 2'b10) begin
      n_fail++;
      $display("FAIL to_write: cs %0d bresp %b want %0d 10", cs_cycles - c0, resp, TO);
    end
    ack_mode = 3;
    slv_mem[12] = 32'hA5C3_0F1E;
    exp_mem[12] = 32'hA5C3_0F1E;
    axi_read(32'h30, 0, data, resp, lat, ok);
    n_tests++;
    if (!ok || lat !== TO + 1 || resp !== 2'b00 || data !== exp_mem[12]) begin
      n_fail++;
      $display("FAIL to_ack_at_expiry: lat %0d rresp %b data %h want %0d 00 %h", lat, resp, data, TO + 1, exp_mem[12]);
    end
    ack_mode = 0;
    axi_read(32'h34, 0, data, resp, lat, ok);
    n_tests++;
    if (!ok || lat !== 2 || resp !== 2'b00 || data !== exp_mem[13]) begin
      n_fail++;
      $display("FAIL to_recover: lat %0d rresp %b data %h want 2 00 %h", lat, resp, data, exp_mem[13]);
    end
  endtask

  task automatic test_rready_stall();
    logic [31:0] d0;
    logic [1:0]  r0;
    int g, c0;
    ack_mode = 1;
    bus.araddr = 32'h10; bus.arvalid = 1'b1; bus.rready = 1'b0;
    #1;
    g = 0;
    while (!bus.arready && g < BUDGET) begin tick(); g++; end
    tick();
    bus.arvalid = 1'b0;
    g = 0;
    while (!bus.rvalid && g < BUDGET) begin tick(); g++; end
    d0 = bus.rdata; r0 = bus.rresp;
    n_tests++;
    if (bus.rvalid !== 1'b1 || d0 !== exp_mem[4] || r0 !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_first: rvalid %b data %h rresp %b want 1 %h 00", bus.rvalid, d0, r0, exp_mem[4]);
    end
    c0 = cs_rises;
    for (int i = 0; i < 5; i++) begin
      stray_ack = (i == 1);
      tick();
      n_tests++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== d0 || bus.rresp !== r0 || bus.local_cs !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: rvalid %b data %h rresp %b cs %b want 1 %h %b 0",
                 i, bus.rvalid, bus.rdata, bus.rresp, bus.local_cs, d0, r0);
      end
    end
    stray_ack = 1'b0;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    n_tests++;
    if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0 || cs_rises - c0 !== 0) begin
      n_fail++;
      $display("FAIL stall_release: rvalid %b rdata %h new_cs %0d want 0 0 0", bus.rvalid, bus.rdata, cs_rises - c0);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    ack_mode = 2;
    bus.araddr = 32'h08; bus.arvalid = 1'b1;
    #1;
    g = 0;
    while (!bus.arready && g < BUDGET) begin tick(); g++; end
    tick();
    bus.arvalid = 1'b0;
    tick();
    n_tests++;
    if (bus.local_cs !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_cs_before: cs %b want 1", bus.local_cs);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.local_cs, bus.local_rnw, bus.local_be,
         bus.local_addr, bus.local_wdata, bus.rdata, bus.bresp, bus.rresp} !== {6'b0, 1'b1, 4'h0, 96'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL rstmid_outputs: cs %b rnw %b be %h addr %h wdata %h rdata %h rvalid %b",
               bus.local_cs, bus.local_rnw, bus.local_be, bus.local_addr, bus.local_wdata, bus.rdata, bus.rvalid);
    end
    rst = 1'b0;
    // Abandon a write mid-access; the next contention must still go to the write
    bus.awaddr = 32'h3C; bus.wdata = $urandom; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #1;
    g = 0;
    while (!bus.awready && g < BUDGET) begin tick(); g++; end
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ack_mode = 0;
    bus.awaddr = 32'h38; bus.wdata = 32'h0BAD_F00D; bus.araddr = 32'h3C;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    #1;
    n_tests++;
    if (!(bus.awready === 1'b1 && bus.arready === 1'b0)) begin
      n_fail++;
      $display("FAIL rstmid_prio: aw %b ar %b want 1 0", bus.awready, bus.arready);
    end
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    g = 0;
    while (!bus.arready && g < BUDGET) begin tick(); g++; end
    tick();
    bus.arvalid = 1'b0;
    repeat (4) tick();
    bus.bready = 1'b0; bus.rready = 1'b0;
    exp_mem[14] = 32'h0BAD_F00D;
  endtask

  task automatic test_random();
    logic [31:0] a, d, data;
    logic [3:0]  s;
    logic [1:0]  resp;
    int mode, dly, lat, c0, exp_lat, exp_cs, idx;
    bit is_wr, ok, tmo;
    for (int n = 0; n < 40; n++) begin
      is_wr = 1'($urandom_range(0, 1));
      idx   = $urandom_range(0, 15);
      a     = 32'(idx) << 2;
      d     = $urandom;
      s     = 4'($urandom_range(0, 15));
      mode  = ($urandom_range(0, 9) == 0) ? 2 : ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 1);
      dly   = $urandom_range(0, 3);
      tmo   = (mode == 2);
      exp_cs  = (mode == 0) ? 1 : (mode == 1) ? 2 : TO;
      exp_lat = exp_cs + 1;
      ack_mode = mode;
      c0 = cs_cycles;
      if (is_wr) begin
        axi_write(a, d, s, dly, resp, lat, ok);
        if (!tmo) exp_mem[idx] = merge(exp_mem[idx], d, s);
        n_tests++;
        if (!ok || lat !== exp_lat || resp !== (tmo ? 2'b10 : 2'b00) || cs_cycles - c0 !== exp_cs) begin
          n_fail++;
          $display("FAIL rand_wr_%0d: mode %0d lat %0d bresp %b cs %0d want %0d %b %0d",
                   n, mode, lat, resp, cs_cycles - c0, exp_lat, tmo ? 2'b10 : 2'b00, exp_cs);
        end
      end else begin
        axi_read(a, dly, data, resp, lat, ok);
        n_tests++;
        if (!ok || lat !== exp_lat || resp !== (tmo ? 2'b10 : 2'b00) || cs_cycles - c0 !== exp_cs ||
            data !== (tmo ? 32'h0 : exp_mem[idx])) begin
          n_fail++;
          $display("FAIL rand_rd_%0d: mode %0d lat %0d rresp %b cs %0d data %h want %0d %b %0d %h",
                   n, mode, lat, resp, cs_cycles - c0, data, exp_lat, tmo ? 2'b10 : 2'b00, exp_cs,
                   tmo ? 32'h0 : exp_mem[idx]);
        end
      end
    end
    n_tests++;
    if (stab_err !== 0) begin
      n_fail++;
      $display("FAIL local_stability: %0d changes while cs high, want 0", stab_err);
    end
  endtask

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    do_reset();
    test_reset();
    test_write_readback();
    test_back_to_back();
    test_arbitration();
    test_timeout();
    test_rready_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
